// File: rtl/reg_stack_seq.sv
`default_nettype none
// ============================================================================
// Module  : reg_stack_seq
// Brief   : Read -> execute -> write sequencer that drives reg_stack from
//           16-bit register-to-register instructions through a 16-bit ALU.
// Rev     : 1.0
// ============================================================================
module reg_stack_seq #(
  parameter int WORD_SIZE = 16,
  parameter int NIB_SIZE  = 4,
  parameter int OP_SIZE   = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            instr_valid,
  input  logic [OP_SIZE+3*NIB_SIZE-1:0]   instr,
  output logic                            instr_ready,
  output logic [NIB_SIZE-1:0]             num1,
  output logic [NIB_SIZE-1:0]             num2,
  output logic [NIB_SIZE-1:0]             setnum,
  output logic [WORD_SIZE-1:0]            setval,
  output logic                            get_enable,
  output logic                            set_enable,
  output logic                            reset_enable,
  input  logic [WORD_SIZE-1:0]            rd1,
  input  logic [WORD_SIZE-1:0]            rd2,
  output logic                            done,
  output logic                            illegal,
  output logic                            flag_z,
  output logic                            flag_c
);

  localparam int INSTR_W = OP_SIZE + 3*NIB_SIZE;
  localparam int IMM_W   = 8;

  localparam logic [OP_SIZE-1:0] c_op_nop = OP_SIZE'(0);
  localparam logic [OP_SIZE-1:0] c_op_add = OP_SIZE'(1);
  localparam logic [OP_SIZE-1:0] c_op_sub = OP_SIZE'(2);
  localparam logic [OP_SIZE-1:0] c_op_and = OP_SIZE'(3);
  localparam logic [OP_SIZE-1:0] c_op_or  = OP_SIZE'(4);
  localparam logic [OP_SIZE-1:0] c_op_xor = OP_SIZE'(5);
  localparam logic [OP_SIZE-1:0] c_op_mov = OP_SIZE'(6);
  localparam logic [OP_SIZE-1:0] c_op_ldi = OP_SIZE'(7);
  localparam logic [OP_SIZE-1:0] c_op_clr = OP_SIZE'(15);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t               r_state;
  logic [INSTR_W-1:0]   r_instr;
  logic [WORD_SIZE-1:0] r_result;
  logic                 r_flag_z;
  logic                 r_flag_c;

  logic [OP_SIZE-1:0]   w_op;
  logic [NIB_SIZE-1:0]  w_rd;
  logic [NIB_SIZE-1:0]  w_rs1;
  logic [NIB_SIZE-1:0]  w_rs2;
  logic [IMM_W-1:0]     w_imm;
  logic [WORD_SIZE:0]   w_sum;
  logic [WORD_SIZE:0]   w_diff;
  logic [WORD_SIZE-1:0] w_alu;
  logic                 w_carry;

  function automatic logic is_alu_op(input logic [OP_SIZE-1:0] op);
    return (op >= c_op_add) && (op <= c_op_mov);
  endfunction

  assign w_op  = r_instr[INSTR_W-1 -: OP_SIZE];
  assign w_rd  = r_instr[3*NIB_SIZE-1 -: NIB_SIZE];
  assign w_rs1 = r_instr[2*NIB_SIZE-1 -: NIB_SIZE];
  assign w_rs2 = r_instr[NIB_SIZE-1:0];
  assign w_imm = r_instr[IMM_W-1:0];

  // Extra top bit of the difference is the unsigned borrow.
  always_comb begin
    w_sum   = {1'b0, rd1} + {1'b0, rd2};
    w_diff  = {1'b0, rd1} - {1'b0, rd2};
    w_alu   = '0;
    w_carry = r_flag_c;
    case (w_op)
      c_op_add: begin w_alu = w_sum[WORD_SIZE-1:0];  w_carry = w_sum[WORD_SIZE];  end
      c_op_sub: begin w_alu = w_diff[WORD_SIZE-1:0]; w_carry = w_diff[WORD_SIZE]; end
      c_op_and: w_alu = rd1 & rd2;
      c_op_or:  w_alu = rd1 | rd2;
      c_op_xor: w_alu = rd1 ^ rd2;
      c_op_mov: w_alu = rd1;
      default:  w_alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_instr  <= '0;
      r_result <= '0;
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_instr <= instr;
            r_state <= is_alu_op(instr[INSTR_W-1 -: OP_SIZE]) ? S_READ : S_WRITE;
          end
        end
        S_READ: r_state <= S_EXEC;
        S_EXEC: begin
          r_result <= w_alu;
          r_flag_z <= (w_alu == '0);
          r_flag_c <= w_carry;
          r_state  <= S_WRITE;
        end
        S_WRITE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instr_ready = rst_n && (r_state == S_IDLE);
  assign flag_z      = r_flag_z;
  assign flag_c      = r_flag_c;

  // Strobes and their index/data buses decode only from registered state.
  always_comb begin
    num1         = '0;
    num2         = '0;
    setnum       = '0;
    setval       = '0;
    get_enable   = 1'b0;
    set_enable   = 1'b0;
    reset_enable = 1'b0;
    done         = 1'b0;
    illegal      = 1'b0;
    case (r_state)
      S_READ: begin
        num1       = w_rs1;
        num2       = w_rs2;
        get_enable = 1'b1;
      end
      S_WRITE: begin
        done = 1'b1;
        if (is_alu_op(w_op)) begin
          set_enable = 1'b1;
          setnum     = w_rd;
          setval     = r_result;
        end else if (w_op == c_op_ldi) begin
          set_enable = 1'b1;
          setnum     = w_rd;
          setval     = {{(WORD_SIZE-IMM_W){1'b0}}, w_imm};
        end else if (w_op == c_op_clr) begin
          reset_enable = 1'b1;
        end else if (w_op != c_op_nop) begin
          illegal = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_stack_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_stack_seq
// Brief   : Scoreboard bench for reg_stack_seq with a reg_stack stand-in.
// Rev     : 1.0
// ============================================================================
module tb_reg_stack_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic [3:0]  num1, num2, setnum;
  logic [15:0] setval;
  logic [15:0] rd1 = '0;
  logic [15:0] rd2 = '0;
  logic        get_enable, set_enable, reset_enable, done, illegal, flag_z, flag_c;

  reg_stack_seq dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .num1(num1), .num2(num2), .setnum(setnum),
    .setval(setval), .get_enable(get_enable), .set_enable(set_enable),
    .reset_enable(reset_enable), .rd1(rd1), .rd2(rd2), .done(done),
    .illegal(illegal), .flag_z(flag_z), .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  // reg_stack stand-in: registered read ports, write and clear-all strobes.
  logic [15:0] env_regs [16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [15:0] pl_val = '0;
  always @(posedge clk) begin
    if (get_enable) begin
      rd1 <= env_regs[num1];
      rd2 <= env_regs[num2];
    end
    if (reset_enable) for (int i = 0; i < 16; i++) env_regs[i] <= '0;
    else if (set_enable) env_regs[setnum] <= setval;
    if (pl_en) env_regs[pl_idx] <= pl_val;
  end

  typedef struct packed {
    logic        set;
    logic        clr;
    logic        ill;
    logic [3:0]  num;
    logic [15:0] val;
    logic        z;
    logic        c;
  } wexp_t;

  wexp_t       wq [$];
  logic [7:0]  rq [$];
  logic [15:0] ref_regs [16];
  logic        ref_z = 1'b0;
  logic        ref_c = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic report(input string name, input string msg);
    n_chk++;
    n_fail++;
    $display("FAIL %s: %s at %0t", name, msg, $time);
  endtask

  // Reference model: one whole instruction at a time, in plain arithmetic.
  task automatic model_push(input logic [15:0] ins);
    logic [3:0]  op, rd, rs1, rs2;
    int unsigned a, b, r;
    wexp_t       e;
    op = ins[15:12]; rd = ins[11:8]; rs1 = ins[7:4]; rs2 = ins[3:0];
    e = '0;
    a = ref_regs[rs1];
    b = ref_regs[rs2];
    r = 0;
    if (op >= 1 && op <= 6) begin
      rq.push_back({rs1, rs2});
      case (op)
        1: begin r = a + b; ref_c = (r > 65535); r = r % 65536; end
        2: begin ref_c = (a < b); r = (a + 65536 - b) % 65536; end
        3: r = a & b;
        4: r = a | b;
        5: r = a ^ b;
        default: r = a;
      endcase
      ref_z = (r == 0);
      ref_regs[rd] = r[15:0];
      e.set = 1'b1; e.num = rd; e.val = r[15:0];
    end else if (op == 7) begin
      e.set = 1'b1; e.num = rd; e.val = {8'h00, ins[7:0]};
      ref_regs[rd] = e.val;
    end else if (op == 15) begin
      e.clr = 1'b1;
      for (int i = 0; i < 16; i++) ref_regs[i] = '0;
    end else if (op != 0) begin
      e.ill = 1'b1;
    end
    e.z = ref_z;
    e.c = ref_c;
    wq.push_back(e);
  endtask

  // All driving happens 1 time unit after a rising edge.
  task automatic issue(input logic [15:0] ins, input bit hold_junk);
    int n = 0;
    while (!instr_ready) begin
      if (hold_junk) begin instr_valid = 1'b1; instr = 16'($urandom); end
      @(posedge clk); #1;
      if (++n > 50) begin
        $display("FAIL issue_timeout: instr_ready=%b, required 1", instr_ready);
        $fatal(1);
      end
    end
    instr = ins;
    instr_valid = 1'b1;
    model_push(ins);
    @(posedge clk); #1;
    instr_valid = hold_junk;
    instr = 16'($urandom);
  endtask

  task automatic quiesce();
    int n = 0;
    while (!instr_ready) begin
      @(posedge clk); #1;
      if (++n > 50) begin
        $display("FAIL quiesce_timeout: instr_ready=%b, required 1", instr_ready);
        $fatal(1);
      end
    end
    instr_valid = 1'b0;
  endtask

  task automatic preload(input logic [3:0] idx, input logic [15:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    ref_regs[idx] = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT strobes or retires.
  initial begin
    wexp_t e;
    bit    lat_on = 1'b0;
    bit    was_rst = 1'b0;
    int    lat_cnt = 0;
    int    lat_exp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lat_on = 1'b0;
        was_rst = 1'b1;
        check("reset_ctrl", {instr_ready, get_enable, set_enable, reset_enable,
                             done, illegal, flag_z, flag_c}, 64'd0);
        check("reset_data", {num1, num2, setnum, setval}, 64'd0);
      end else begin
        if (was_rst) begin
          check("ready_after_reset", instr_ready, 64'd1);
          was_rst = 1'b0;
        end
        check("strobe_onehot", ($countones({get_enable, set_enable, reset_enable}) > 1), 64'd0);
        if (!get_enable) check("idle_read_idx", {num1, num2}, 64'd0);
        if (!set_enable) check("idle_write_data", {setnum, setval}, 64'd0);
        if (get_enable) begin
          if (rq.size() == 0) report("unexpected_read", "get_enable with no read expected");
          else check("read_idx", {num1, num2}, rq.pop_front());
        end
        if (done) begin
          if (wq.size() == 0) report("unexpected_done", "done with no instruction pending");
          else begin
            e = wq.pop_front();
            check("retire", {set_enable, reset_enable, illegal, setnum, setval},
                            {e.set, e.clr, e.ill, e.num, e.val});
            check("flags", {flag_z, flag_c}, {e.z, e.c});
          end
        end else begin
          check("no_retire_strobe", {set_enable, reset_enable, illegal}, 64'd0);
        end
        if (lat_on) begin
          lat_cnt++;
          if (instr_ready) begin
            check("accept_latency", lat_cnt, lat_exp);
            lat_on = 1'b0;
          end else if (lat_cnt > 10) begin
            report("accept_latency", "instr_ready did not return");
            lat_on = 1'b0;
          end
        end
        if (instr_valid && instr_ready) begin
          lat_on = 1'b1;
          lat_cnt = 0;
          lat_exp = (instr[15:12] >= 4'd1 && instr[15:12] <= 4'd6) ? 4 : 2;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) ref_regs[i] = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    issue(16'hF000, 1'b0);
    quiesce();
    preload(4'd9, 16'hAF53);
    preload(4'd10, 16'h50AD);
    issue(16'h1A9A, 1'b0);
    quiesce();
    preload(4'd1, 16'h0005);
    preload(4'd2, 16'h0007);
    issue(16'h2312, 1'b0);
    issue(16'h3456, 1'b0);
    issue(16'h73A5, 1'b0);
    issue(16'h9123, 1'b0);
    issue(16'h0ABC, 1'b0);
    issue(16'hE111, 1'b0);
    issue(16'h4123, 1'b1);
    issue(16'h5321, 1'b1);
    issue(16'h6A70, 1'b1);
    issue(16'h1337, 1'b1);
    issue(16'hF000, 1'b1);
    quiesce();

    // Abort an ADD in EXEC: only its read may be seen, never its write.
    instr = 16'h1A9A;
    instr_valid = 1'b1;
    rq.push_back({4'h9, 4'hA});
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    ref_z = 1'b0;
    ref_c = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) preload(4'(i), 16'($urandom));
    preload(4'd3, 16'hFFFF);
    preload(4'd4, 16'h0001);
    issue(16'h1534, 1'b0);
    for (int k = 0; k < 80; k++) issue(16'($urandom), bit'($urandom_range(0, 1)));
    quiesce();
    repeat (3) @(posedge clk);
    if (wq.size() != 0 || rq.size() != 0)
      report("drain", $sformatf("%0d writes and %0d reads never seen", wq.size(), rq.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
